// File: rtl/core_wbu_top.sv
// Write-back stage: accepts execute-stage result bundles, picks the destination
// data from one-hot source flags and drives the single GPR write port.
module core_wbu_top #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wbu_rx_valid,
  output logic                 wbu_rx_ready,
  input  logic [31:0]          wbu_rx_exu_res,
  input  logic [31:0]          wbu_rx_pc,
  input  logic [31:0]          wbu_rx_pc_seq,
  input  logic [31:0]          wbu_rx_imme,
  input  logic [31:0]          wbu_rx_csr_rdata,
  input  logic                 wbu_rx_imme_valid,
  input  logic                 wbu_rx_pc_valid,
  input  logic                 wbu_rx_pc_seq_valid,
  input  logic                 wbu_rx_csr_valid,
  input  logic                 wbu_rx_alu_valid,
  input  logic [4:0]           wbu_rx_rd_idx,
  output logic                 gpr_wr_en,
  input  logic                 gpr_wr_ready,
  output logic [4:0]           gpr_wr_idx,
  output logic [31:0]          gpr_wr_data,
  output logic [INSTRET_W-1:0] wbu_instret,
  output logic                 wbu_sel_err
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             wr_idx_q, wr_idx_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   sel_err_q, sel_err_d;

  logic [4:0]  sel;
  logic        rx_ena;
  logic        wr_ena;
  logic        wr_need;
  logic        multi_sel;
  logic [31:0] rx_data;

  // Fixed priority: alu, csr, pc_seq, pc (+imme), imme.
  function automatic logic [31:0] pick_data(
    input logic [4:0]  s,
    input logic [31:0] exu_res,
    input logic [31:0] csr_rdata,
    input logic [31:0] pc_seq,
    input logic [31:0] pc,
    input logic [31:0] imme
  );
    logic [31:0] d;
    d = 32'd0;
    if (s[0])      d = exu_res;
    else if (s[1]) d = csr_rdata;
    else if (s[2]) d = pc_seq;
    else if (s[3]) d = pc + imme;
    else if (s[4]) d = imme;
    return d;
  endfunction

  assign sel = {wbu_rx_imme_valid, wbu_rx_pc_valid, wbu_rx_pc_seq_valid,
                wbu_rx_csr_valid, wbu_rx_alu_valid};

  assign gpr_wr_en    = (state_q == S_WRITE);
  assign wbu_rx_ready = (state_q == S_IDLE) || gpr_wr_ready;
  assign rx_ena       = wbu_rx_valid && wbu_rx_ready;
  assign wr_ena       = gpr_wr_en && gpr_wr_ready;
  assign wr_need      = (|sel) && (wbu_rx_rd_idx != 5'd0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_sel    = |(sel & (sel - 5'd1));
  assign rx_data      = pick_data(sel, wbu_rx_exu_res, wbu_rx_csr_rdata,
                                  wbu_rx_pc_seq, wbu_rx_pc, wbu_rx_imme);

  assign gpr_wr_idx  = wr_idx_q;
  assign gpr_wr_data = wr_data_q;
  assign wbu_instret = instret_q;
  assign wbu_sel_err = sel_err_q;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    instret_d = instret_q + INSTRET_W'(rx_ena);
    sel_err_d = sel_err_q | (rx_ena & multi_sel);
    case (state_q)
      S_IDLE: begin
        if (rx_ena && wr_need) begin
          wr_idx_d  = wbu_rx_rd_idx;
          wr_data_d = rx_data;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ena) begin
          if (rx_ena && wr_need) begin
            wr_idx_d  = wbu_rx_rd_idx;
            wr_data_d = rx_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_idx_q  <= 5'd0;
      wr_data_q <= 32'd0;
      instret_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      instret_q <= instret_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_core_wbu_top.sv
// Self-checking bench for core_wbu_top: an ordered scoreboard of expected GPR
// writes plus directed vectors, run on a 64-bit and a 4-bit counter build.
module tb_core_wbu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [31:0] exu_res, pc, pc_seq, imme, csr_rdata;
  logic [4:0]  sel;  // {imme, pc, pc_seq, csr, alu}
  logic [4:0]  rd;
  logic        gpr_wr_ready;

  logic        rx_ready, wr_en, err;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [63:0] instret;

  logic        rx_ready4, wr_en4, err4;
  logic [4:0]  wr_idx4;
  logic [31:0] wr_data4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] acc_m;
  bit          err_m;

  always #5 clk = ~clk;

  core_wbu_top dut (
    .clk(clk), .rst(rst),
    .wbu_rx_valid(rx_valid), .wbu_rx_ready(rx_ready),
    .wbu_rx_exu_res(exu_res), .wbu_rx_pc(pc), .wbu_rx_pc_seq(pc_seq),
    .wbu_rx_imme(imme), .wbu_rx_csr_rdata(csr_rdata),
    .wbu_rx_imme_valid(sel[4]), .wbu_rx_pc_valid(sel[3]),
    .wbu_rx_pc_seq_valid(sel[2]), .wbu_rx_csr_valid(sel[1]),
    .wbu_rx_alu_valid(sel[0]), .wbu_rx_rd_idx(rd),
    .gpr_wr_en(wr_en), .gpr_wr_ready(gpr_wr_ready),
    .gpr_wr_idx(wr_idx), .gpr_wr_data(wr_data),
    .wbu_instret(instret), .wbu_sel_err(err)
  );

  core_wbu_top #(.INSTRET_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .wbu_rx_valid(rx_valid), .wbu_rx_ready(rx_ready4),
    .wbu_rx_exu_res(exu_res), .wbu_rx_pc(pc), .wbu_rx_pc_seq(pc_seq),
    .wbu_rx_imme(imme), .wbu_rx_csr_rdata(csr_rdata),
    .wbu_rx_imme_valid(sel[4]), .wbu_rx_pc_valid(sel[3]),
    .wbu_rx_pc_seq_valid(sel[2]), .wbu_rx_csr_valid(sel[1]),
    .wbu_rx_alu_valid(sel[0]), .wbu_rx_rd_idx(rd),
    .gpr_wr_en(wr_en4), .gpr_wr_ready(gpr_wr_ready),
    .gpr_wr_idx(wr_idx4), .gpr_wr_data(wr_data4),
    .wbu_instret(instret4), .wbu_sel_err(err4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_data(input logic [4:0] s);
    if (s[0]) return exu_res;
    if (s[1]) return csr_rdata;
    if (s[2]) return pc_seq;
    if (s[3]) return pc + imme;
    if (s[4]) return imme;
    return 32'd0;
  endfunction

  // Outputs are compared at the falling edge against the model state; then
  // the handshakes about to complete at the next rising edge update the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_m = 64'd0;
      err_m = 1'b0;
    end else begin
      bit exp_ready;
      exp_ready = (exp_q.size() == 0) || gpr_wr_ready;
      chk("m_instret", instret, acc_m);
      chk("m_instret4", {60'd0, instret4}, {60'd0, acc_m[3:0]});
      chk("m_sel_err", {63'd0, err}, {63'd0, err_m});
      chk("m_wr_en", {63'd0, wr_en}, {63'd0, exp_q.size() != 0});
      chk("m_wr_en4", {63'd0, wr_en4}, {63'd0, exp_q.size() != 0});
      chk("m_rx_ready", {63'd0, rx_ready}, {63'd0, exp_ready});
      if (exp_q.size() != 0) begin
        chk("m_wr_idx", {59'd0, wr_idx}, {59'd0, exp_q[0].idx});
        chk("m_wr_data", {32'd0, wr_data}, {32'd0, exp_q[0].data});
      end
      if (exp_q.size() != 0 && gpr_wr_ready) void'(exp_q.pop_front());
      if (rx_valid && exp_ready) begin
        acc_m = acc_m + 64'd1;
        if ((|sel) && rd != 5'd0) exp_q.push_back('{idx: rd, data: model_data(sel)});
        if ($countones(sel) > 1) err_m = 1'b1;
      end
    end
  end

  task automatic idle_inputs();
    rx_valid = 1'b0; sel = 5'd0; rd = 5'd0;
    exu_res = 32'd0; pc = 32'd0; pc_seq = 32'd0; imme = 32'd0; csr_rdata = 32'd0;
  endtask

  // Presents a bundle until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [4:0] s, input logic [4:0] r, input logic [31:0] e,
                      input logic [31:0] p, input logic [31:0] ps,
                      input logic [31:0] im, input logic [31:0] c);
    bit ok;
    sel = s; rd = r; exu_res = e; pc = p; pc_seq = ps; imme = im; csr_rdata = c;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gpr_wr_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_idx", {59'd0, wr_idx}, 64'd0);
    chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_sel_err", {63'd0, err}, 64'd0);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    rst = 1'b0;

    // Single alu write
    send(5'b00001, 5'd5, 32'h0000_1234, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("alu_wr_en", {63'd0, wr_en}, 64'd1);
    chk("alu_idx", {59'd0, wr_idx}, 64'd5);
    chk("alu_data", {32'd0, wr_data}, 64'h1234);
    @(posedge clk); #1;
    chk("alu_wr_en_drop", {63'd0, wr_en}, 64'd0);
    chk("alu_instret", instret, 64'd1);

    // auipc, lui, jal back to back
    send(5'b01000, 5'd3, 32'd0, 32'h8000_0000, 32'd0, 32'h0000_1000, 32'd0);
    chk("auipc_data", {32'd0, wr_data}, 64'h8000_1000);
    send(5'b10000, 5'd4, 32'd0, 32'd0, 32'd0, 32'hFFFF_F000, 32'd0);
    chk("lui_data", {32'd0, wr_data}, 64'hFFFF_F000);
    send(5'b00100, 5'd1, 32'd0, 32'h8000_0000, 32'h8000_0004, 32'h0000_0010, 32'd0);
    chk("jal_data", {32'd0, wr_data}, 64'h8000_0004);
    chk("jal_idx", {59'd0, wr_idx}, 64'd1);
    @(posedge clk); #1;

    // rd=0 and a no-destination bundle retire without writing
    send(5'b00001, 5'd0, 32'hCAFE_F00D, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rd0_wr_en", {63'd0, wr_en}, 64'd0);
    send(5'b00000, 5'd7, 32'h1111_1111, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("nosel_wr_en", {63'd0, wr_en}, 64'd0);
    chk("nosel_rx_ready", {63'd0, rx_ready}, 64'd1);
    chk("nosel_instret", instret, 64'd6);

    // Backpressure: pending write held for 3 cycles while next bundle waits
    gpr_wr_ready = 1'b0;
    send(5'b00001, 5'd7, 32'h0000_0077, 32'd0, 32'd0, 32'd0, 32'd0);
    sel = 5'b00001; rd = 5'd8; exu_res = 32'h0000_0088; rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rx_ready", {63'd0, rx_ready}, 64'd0);
      chk("bp_idx", {59'd0, wr_idx}, 64'd7);
      chk("bp_data", {32'd0, wr_data}, 64'h77);
    end
    @(posedge clk); #1 gpr_wr_ready = 1'b1;
    @(posedge clk); #1 idle_inputs();
    chk("bp_second_en", {63'd0, wr_en}, 64'd1);
    chk("bp_second_idx", {59'd0, wr_idx}, 64'd8);
    chk("bp_second_data", {32'd0, wr_data}, 64'h88);
    @(posedge clk); #1;
    chk("bp_drain", {63'd0, wr_en}, 64'd0);
    chk("bp_instret", instret, 64'd8);

    // Multi-hot select: priority still alu, sticky error
    send(5'b00011, 5'd9, 32'h0000_000A, 32'd0, 32'd0, 32'd0, 32'h0000_000B);
    chk("multi_data", {32'd0, wr_data}, 64'hA);
    chk("multi_err", {63'd0, err}, 64'd1);
    repeat (10) @(posedge clk);
    #1 chk("multi_err_sticky", {63'd0, err}, 64'd1);

    // Async reset while a write is stalled
    gpr_wr_ready = 1'b0;
    send(5'b00001, 5'd10, 32'h0000_DEAD, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("ar_pending", {63'd0, wr_en}, 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_wr_en", {63'd0, wr_en}, 64'd0);
    chk("ar_instret", instret, 64'd0);
    chk("ar_sel_err", {63'd0, err}, 64'd0);
    chk("ar_idx", {59'd0, wr_idx}, 64'd0);
    @(posedge clk); #1 rst = 1'b0; gpr_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ar_no_commit", {63'd0, wr_en}, 64'd0);
    end

    // 4-bit counter wrap
    for (int i = 0; i < 15; i++) send(5'b00000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("wrap_15", {60'd0, instret4}, 64'hF);
    send(5'b00000, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("wrap_0", {60'd0, instret4}, 64'd0);
    chk("wrap_wide", instret, 64'd16);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
